// File: rtl/rv_enc_pkg.sv
// Shared definitions for the RV32I instruction encoder: operation and state
// enums plus the opcode, funct3 and funct7 field constants.
package rv_enc_pkg;

    typedef enum logic [4:0] {
        OP_ADD  = 5'd0,
        OP_SUB  = 5'd1,
        OP_AND  = 5'd2,
        OP_OR   = 5'd3,
        OP_XOR  = 5'd4,
        OP_SLL  = 5'd5,
        OP_SRL  = 5'd6,
        OP_SRA  = 5'd7,
        OP_HAMD = 5'd8,
        OP_ADDI = 5'd9,
        OP_ANDI = 5'd10,
        OP_ORI  = 5'd11,
        OP_XORI = 5'd12,
        OP_SLLI = 5'd13,
        OP_SRLI = 5'd14,
        OP_SRAI = 5'd15,
        OP_LW   = 5'd16,
        OP_JALR = 5'd17,
        OP_SW   = 5'd18,
        OP_BEQ  = 5'd19,
        OP_BNE  = 5'd20,
        OP_LUI  = 5'd21,
        OP_JAL  = 5'd22,
        OP_LI   = 5'd23
    } op_e;

    // Every encoding at or above this value is rejected with an err pulse.
    localparam logic [4:0] OP_FIRST_ILLEGAL = 5'd24;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ONE   = 2'd1,
        FIRST = 2'd2
    } state_e;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;
    localparam logic [2:0] F3_WORD = 3'b010;
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

endpackage

// File: rtl/rv_enc_format.sv
// Purely combinational field packer: one abstract RV32I operation in, one
// 32-bit machine word out. LI and illegal ops produce zero here.
module rv_enc_format
    import rv_enc_pkg::*;
(
    input  logic [4:0]  op,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [31:0] imm,
    output logic [31:0] word
);

    always_comb begin
        word = '0;
        case (op)
            OP_ADD:  word = {F7_BASE, rs2, rs1, F3_ADD, rd, OPC_OP};
            OP_SUB:  word = {F7_ALT,  rs2, rs1, F3_ADD, rd, OPC_OP};
            OP_AND:  word = {F7_BASE, rs2, rs1, F3_AND, rd, OPC_OP};
            OP_OR:   word = {F7_BASE, rs2, rs1, F3_OR,  rd, OPC_OP};
            OP_XOR:  word = {F7_BASE, rs2, rs1, F3_XOR, rd, OPC_OP};
            OP_SLL:  word = {F7_BASE, rs2, rs1, F3_SLL, rd, OPC_OP};
            OP_SRL:  word = {F7_BASE, rs2, rs1, F3_SR,  rd, OPC_OP};
            OP_SRA:  word = {F7_ALT,  rs2, rs1, F3_SR,  rd, OPC_OP};
            OP_HAMD: word = {F7_ALT,  rs2, rs1, F3_AND, rd, OPC_OP};
            OP_ADDI: word = {imm[11:0], rs1, F3_ADD, rd, OPC_OP_IMM};
            OP_ANDI: word = {imm[11:0], rs1, F3_AND, rd, OPC_OP_IMM};
            OP_ORI:  word = {imm[11:0], rs1, F3_OR,  rd, OPC_OP_IMM};
            OP_XORI: word = {imm[11:0], rs1, F3_XOR, rd, OPC_OP_IMM};
            // Shift-immediates carry funct7 in the upper immediate bits.
            OP_SLLI: word = {F7_BASE, imm[4:0], rs1, F3_SLL, rd, OPC_OP_IMM};
            OP_SRLI: word = {F7_BASE, imm[4:0], rs1, F3_SR,  rd, OPC_OP_IMM};
            OP_SRAI: word = {F7_ALT,  imm[4:0], rs1, F3_SR,  rd, OPC_OP_IMM};
            OP_LW:   word = {imm[11:0], rs1, F3_WORD, rd, OPC_LOAD};
            OP_JALR: word = {imm[11:0], rs1, F3_ADD,  rd, OPC_JALR};
            OP_SW:   word = {imm[11:5], rs2, rs1, F3_WORD, imm[4:0], OPC_STORE};
            OP_BEQ:  word = {imm[12], imm[10:5], rs2, rs1, F3_BEQ,
                             imm[4:1], imm[11], OPC_BRANCH};
            OP_BNE:  word = {imm[12], imm[10:5], rs2, rs1, F3_BNE,
                             imm[4:1], imm[11], OPC_BRANCH};
            OP_LUI:  word = {imm[31:12], rd, OPC_LUI};
            OP_JAL:  word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OPC_JAL};
            default: word = '0;
        endcase
    end

endmodule

// File: rtl/rv_inst_encoder.sv
// Streaming RV32I encoder: accepts abstract ops over valid/ready, emits
// machine words with sequential word addresses, expanding LI to LUI+ADDI.
module rv_inst_encoder
    import rv_enc_pkg::*;
#(
    parameter int          ADDR_W    = 8,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        in_op,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [31:0]       in_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_inst,
    output logic [ADDR_W-1:0] out_addr,
    output logic              err
);

    state_e      state, state_next;
    logic [31:0] inst_next, pend, pend_next;
    logic        err_next;
    logic        in_fire, out_fire, is_illegal, is_li, li_two;
    logic [19:0] li_hi;
    logic [4:0]  fmt_op, fmt_rs1;
    logic [31:0] fmt_imm, fmt_word, addi_word;

    assign out_valid  = (state != IDLE);
    assign in_ready   = (state == IDLE) || ((state == ONE) && out_ready);
    assign in_fire    = in_valid && in_ready;
    assign out_fire   = out_valid && out_ready;
    assign is_illegal = (in_op >= OP_FIRST_ILLEGAL);
    assign is_li      = (in_op == OP_LI);

    // ADDI sign-extends its 12-bit immediate, so the upper part is rounded up
    // whenever bit 11 is set.
    assign li_hi  = in_imm[31:12] + 20'(in_imm[11]);
    assign li_two = (li_hi != 20'd0);

    always_comb begin
        fmt_op  = in_op;
        fmt_rs1 = in_rs1;
        fmt_imm = in_imm;
        if (is_li) begin
            fmt_op  = li_two ? OP_LUI : OP_ADDI;
            fmt_rs1 = 5'd0;
            fmt_imm = li_two ? {li_hi, 12'd0} : in_imm;
        end
    end

    rv_enc_format u_fmt_main (
        .op   (fmt_op),
        .rd   (in_rd),
        .rs1  (fmt_rs1),
        .rs2  (in_rs2),
        .imm  (fmt_imm),
        .word (fmt_word)
    );

    rv_enc_format u_fmt_addi (
        .op   (OP_ADDI),
        .rd   (in_rd),
        .rs1  (in_rd),
        .rs2  (5'd0),
        .imm  (in_imm),
        .word (addi_word)
    );

    // An accept always wins over a plain fire: from ONE it only happens
    // when the held word is leaving in the same cycle.
    always_comb begin
        state_next = state;
        inst_next  = out_inst;
        pend_next  = pend;
        err_next   = 1'b0;
        if (in_fire) begin
            if (is_illegal) begin
                err_next   = 1'b1;
                state_next = IDLE;
            end else if (is_li && li_two) begin
                inst_next  = fmt_word;
                pend_next  = addi_word;
                state_next = FIRST;
            end else begin
                inst_next  = fmt_word;
                state_next = ONE;
            end
        end else if (out_fire) begin
            if (state == FIRST) begin
                inst_next  = pend;
                state_next = ONE;
            end else begin
                state_next = IDLE;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            out_inst <= '0;
            pend     <= '0;
            err      <= 1'b0;
            out_addr <= ADDR_W'(BASE_ADDR);
        end else begin
            state    <= state_next;
            out_inst <= inst_next;
            pend     <= pend_next;
            err      <= err_next;
            if (out_fire) begin
                out_addr <= out_addr + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rv_inst_encoder.sv
// Directed bench for rv_inst_encoder with hand-computed instruction words,
// plus a 2-bit address instance to exercise counter wrap.
module tb_rv_inst_encoder;
    import rv_enc_pkg::*;

    logic        clock;
    logic        reset;
    logic        in_valid, in_ready, out_valid, out_ready, err;
    logic [4:0]  in_op, in_rd, in_rs1, in_rs2;
    logic [31:0] in_imm, out_inst;
    logic [7:0]  out_addr;

    logic        in_valid2, in_ready2, out_valid2, out_ready2, err2;
    logic [31:0] out_inst2;
    logic [1:0]  out_addr2;

    int total = 0;
    int bad   = 0;
    int exp_addr;

    typedef struct {
        logic [4:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [10];

    rv_inst_encoder #(.ADDR_W(8), .BASE_ADDR(0)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_rd     (in_rd),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .in_imm    (in_imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_inst  (out_inst),
        .out_addr  (out_addr),
        .err       (err)
    );

    rv_inst_encoder #(.ADDR_W(2), .BASE_ADDR(0)) dut_small (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid2),
        .in_ready  (in_ready2),
        .in_op     (OP_ADDI),
        .in_rd     (5'd1),
        .in_rs1    (5'd0),
        .in_rs2    (5'd0),
        .in_imm    (32'd5),
        .out_valid (out_valid2),
        .out_ready (out_ready2),
        .out_inst  (out_inst2),
        .out_addr  (out_addr2),
        .err       (err2)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Every comparison in the bench funnels through here.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Present a request and return #1 after the edge that accepted it.
    task automatic applyStimulus(input logic [4:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                                 input logic [4:0] rs2, input logic [31:0] imm);
        int waited = 0;
        in_valid = 1'b1;
        in_op    = op;
        in_rd    = rd;
        in_rs1   = rs1;
        in_rs2   = rs2;
        in_imm   = imm;
        while (!in_ready && waited < 50) begin
            @(posedge clock);
            #1;
            waited++;
        end
        if (!in_ready) begin
            checkOutput("accept_timeout", 32'd0, 32'd1);
        end else begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic idleCycle();
        in_valid = 1'b0;
        @(posedge clock);
        #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0] = '{OP_SRAI, 5'd4, 5'd4, 5'd0, 32'd3,          32'h40325213};
        vecs[1] = '{OP_BEQ,  5'd0, 5'd1, 5'd2, 32'hFFFFFFF8,   32'hFE208CE3};
        vecs[2] = '{OP_SUB,  5'd1, 5'd2, 5'd3, 32'd0,          32'h403100B3};
        vecs[3] = '{OP_SW,   5'd0, 5'd1, 5'd2, 32'd8,          32'h0020A423};
        vecs[4] = '{OP_JAL,  5'd1, 5'd0, 5'd0, 32'd16,         32'h010000EF};
        vecs[5] = '{OP_LW,   5'd5, 5'd6, 5'd0, 32'd4,          32'h00432283};
        vecs[6] = '{OP_BNE,  5'd0, 5'd3, 5'd4, 32'd12,         32'h00419663};
        vecs[7] = '{OP_LUI,  5'd7, 5'd0, 5'd0, 32'hABCDE123,   32'hABCDE3B7};
        vecs[8] = '{OP_XORI, 5'd1, 5'd2, 5'd9, 32'hFFFFFFFF,   32'hFFF14093};
        vecs[9] = '{OP_SLL,  5'd1, 5'd2, 5'd3, 32'd0,          32'h003110B3};

        reset      = 1'b1;
        in_valid   = 1'b0;
        in_op      = '0;
        in_rd      = '0;
        in_rs1     = '0;
        in_rs2     = '0;
        in_imm     = '0;
        out_ready  = 1'b0;
        in_valid2  = 1'b0;
        out_ready2 = 1'b0;

        #12;
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_out_inst",  out_inst,       32'd0);
        checkOutput("rst_out_addr",  32'(out_addr),  32'd0);
        checkOutput("rst_err",       32'(err),       32'd0);
        checkOutput("rst_in_ready",  32'(in_ready),  32'd1);
        @(posedge clock);
        #1;
        reset = 1'b0;

        $display("[TB] basic R-type words");
        out_ready = 1'b1;
        applyStimulus(OP_ADD, 5'd3, 5'd1, 5'd2, 32'd0);
        checkOutput("add_valid", 32'(out_valid), 32'd1);
        checkOutput("add_inst",  out_inst,       32'h002081B3);
        checkOutput("add_addr",  32'(out_addr),  32'd0);
        checkOutput("add_err",   32'(err),       32'd0);
        applyStimulus(OP_HAMD, 5'd5, 5'd6, 5'd7, 32'd0);
        checkOutput("hamd_inst", out_inst,       32'h407372B3);
        checkOutput("hamd_addr", 32'(out_addr),  32'd1);
        exp_addr = 1;

        $display("[TB] back-to-back table");
        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i].op, vecs[i].rd, vecs[i].rs1, vecs[i].rs2, vecs[i].imm);
            exp_addr++;
            checkOutput($sformatf("tbl%0d_inst", i), out_inst, vecs[i].exp);
            checkOutput($sformatf("tbl%0d_addr", i), 32'(out_addr), 32'(exp_addr));
        end
        idleCycle();
        exp_addr++;
        checkOutput("drain_valid", 32'(out_valid), 32'd0);
        checkOutput("drain_addr",  32'(out_addr),  32'(exp_addr));

        $display("[TB] LI expansion");
        applyStimulus(OP_LI, 5'd10, 5'd0, 5'd0, 32'h12345FFF);
        in_valid = 1'b0;
        checkOutput("li_lui_inst",    out_inst,       32'h12346537);
        checkOutput("li_lui_addr",    32'(out_addr),  32'(exp_addr));
        checkOutput("li_first_ready", 32'(in_ready),  32'd0);
        @(posedge clock);
        #1;
        exp_addr++;
        checkOutput("li_addi_inst",   out_inst,       32'hFFF50513);
        checkOutput("li_addi_addr",   32'(out_addr),  32'(exp_addr));
        idleCycle();
        exp_addr++;
        checkOutput("li_done_valid",  32'(out_valid), 32'd0);
        applyStimulus(OP_LI, 5'd1, 5'd0, 5'd0, 32'h000007FF);
        checkOutput("li_small_inst",  out_inst,       32'h7FF00093);
        checkOutput("li_small_addr",  32'(out_addr),  32'(exp_addr));
        checkOutput("li_small_ready", 32'(in_ready),  32'd1);
        idleCycle();
        exp_addr++;
        checkOutput("li_small_done",  32'(out_valid), 32'd0);

        $display("[TB] backpressure");
        out_ready = 1'b0;
        applyStimulus(OP_ADD, 5'd3, 5'd1, 5'd2, 32'd0);
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checkOutput($sformatf("stall%0d_inst", i),  out_inst,      32'h002081B3);
            checkOutput($sformatf("stall%0d_addr", i),  32'(out_addr), 32'(exp_addr));
            checkOutput($sformatf("stall%0d_ready", i), 32'(in_ready), 32'd0);
            @(posedge clock);
            #1;
        end
        checkOutput("stall_valid", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        @(posedge clock);
        #1;
        exp_addr++;
        checkOutput("release_valid", 32'(out_valid), 32'd0);
        checkOutput("release_addr",  32'(out_addr),  32'(exp_addr));

        $display("[TB] illegal ops");
        applyStimulus(5'd27, 5'd1, 5'd1, 5'd1, 32'd0);
        in_valid = 1'b0;
        checkOutput("ill_err",   32'(err),       32'd1);
        checkOutput("ill_valid", 32'(out_valid), 32'd0);
        checkOutput("ill_addr",  32'(out_addr),  32'(exp_addr));
        @(posedge clock);
        #1;
        checkOutput("ill_err_pulse", 32'(err),       32'd0);
        checkOutput("ill_valid2",    32'(out_valid), 32'd0);
        applyStimulus(OP_ADD, 5'd3, 5'd1, 5'd2, 32'd0);
        applyStimulus(5'd31, 5'd0, 5'd0, 5'd0, 32'd0);
        in_valid = 1'b0;
        exp_addr++;
        checkOutput("ill_one_err",   32'(err),       32'd1);
        checkOutput("ill_one_valid", 32'(out_valid), 32'd0);
        checkOutput("ill_one_addr",  32'(out_addr),  32'(exp_addr));

        $display("[TB] reset during LI");
        out_ready = 1'b0;
        applyStimulus(OP_LI, 5'd10, 5'd0, 5'd0, 32'h12345FFF);
        in_valid = 1'b0;
        checkOutput("rli_lui_inst", out_inst, 32'h12346537);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("rli_valid", 32'(out_valid), 32'd0);
        checkOutput("rli_addr",  32'(out_addr),  32'd0);
        checkOutput("rli_inst",  out_inst,       32'd0);
        @(posedge clock);
        #1;
        reset     = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clock);
            #1;
            checkOutput($sformatf("rli_post%0d_valid", i), 32'(out_valid), 32'd0);
        end
        checkOutput("rli_post_addr", 32'(out_addr), 32'd0);

        $display("[TB] 2-bit address wrap");
        in_valid2  = 1'b1;
        out_ready2 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clock);
            #1;
            checkOutput($sformatf("wrap%0d_valid", i), 32'(out_valid2), 32'd1);
            checkOutput($sformatf("wrap%0d_addr", i),  32'(out_addr2),  32'(i % 4));
            checkOutput($sformatf("wrap%0d_inst", i),  out_inst2,       32'h00500093);
        end
        in_valid2 = 1'b0;
        checkOutput("wrap_err", 32'(err2), 32'd0);
        checkOutput("wrap_ready", 32'(in_ready2), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rv_inst_encoder.md
Name: rv_inst_encoder

Overview:
- Streaming RV32I instruction encoder: the inverse of the single-cycle control unit's decoding.
- Accepts an abstract operation (enum op, rd, rs1, rs2, imm) over a valid/ready handshake.
- Emits 32-bit machine words with sequential word addresses, for loading instruction memory from a bench or boot loader.
- Supports every instruction the control unit decodes (including custom HAMD), plus an LI pseudo-op that expands to LUI+ADDI.

Parameters:
- ADDR_W, 8, width of the output word-address counter.
- BASE_ADDR, 0, value the address counter takes at reset.

Ports:
- clock     input   1       rising-edge clock.
- reset     input   1       asynchronous, active-high reset.
- in_valid  input   1       request valid.
- in_ready  output  1       encoder can accept a request this cycle.
- in_op     input   5       operation enum (see package).
- in_rd     input   5       destination register.
- in_rs1    input   5       source register 1.
- in_rs2    input   5       source register 2.
- in_imm    input   32      immediate; byte offset for branch/JAL; value for LI/LUI (LUI uses imm[31:12]).
- out_valid output  1       out_inst/out_addr valid.
- out_ready input   1       consumer accepts the word.
- out_inst  output  32      encoded instruction.
- out_addr  output  ADDR_W  word address of out_inst.
- err       output  1       1-cycle pulse when an illegal op is accepted.

Behaviour:
- Reset (async, any time, including mid-LI): out_valid=0, out_inst=0, out_addr=BASE_ADDR, err=0, state=IDLE, pending second word discarded.
- Handshakes:
  - Input fires when in_valid & in_ready.
  - Output fires when out_valid & out_ready.
  - out_inst and out_addr are held stable while out_valid & ~out_ready.
- States:
  - IDLE: no word held.
  - ONE: holding a single word, or the last word of a sequence.
  - FIRST: holding LUI of an LI, with ADDI pending.
- in_ready = (state==IDLE) | (state==ONE & out_ready). It is combinational from state and out_ready, never from in_valid.
- Latency and throughput:
  - Accepted request produces out_valid on the next cycle.
  - Sustained throughput is 1 word/cycle for non-LI ops.
- Transitions:
  - IDLE/ONE on accept of a legal non-LI op -> ONE.
  - Accept of LI with two-word expansion -> FIRST.
  - FIRST on output fire -> ONE (ADDI word). in_ready=0 throughout FIRST.
  - ONE on output fire with no accept -> IDLE.
- out_addr increments by 1 only on output fire; it wraps modulo 2^ADDR_W.
- Illegal op (enum 24..31) on accept:
  - err=1 for exactly one cycle; nothing is emitted; address is unchanged.
  - If accepted from ONE while the held word fires that cycle, next state is IDLE.
- Encodings:
  - R (op 0110011): funct7|rs2|rs1|f3|rd|op.
    - f3: ADD/SUB 000, SLL 001, XOR 100, SRL/SRA 101, OR 110, AND/HAMD 111.
    - funct7=0100000 for SUB, SRA, HAMD; 0 otherwise.
  - I (0010011): imm[11:0]|rs1|f3|rd|op; f3 mirrors the R-type values.
    - SLLI/SRLI/SRAI: imm field = {funct7, imm[4:0]}, with funct7=0100000 only for SRAI; imm[31:5] ignored.
  - LW: 0000011, f3=010. JALR: 1100111, f3=000.
  - SW: 0100011, f3=010; imm split into [11:5] and [4:0].
  - BEQ/BNE: 1100011, f3 000/001; field order imm[12]|imm[10:5]|rs2|rs1|f3|imm[4:1]|imm[11]|op. imm[0] ignored.
  - LUI: imm[31:12]|rd|0110111.
  - JAL: imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|1101111.
  - Fields unused by a format are ignored: rs2 for I-type, rd for S/B.
- LI rd, imm:
  - hi = imm[31:12] + imm[11] (mod 2^20).
  - hi != 0: emit LUI rd,hi, then ADDI rd,rd,imm[11:0].
  - hi == 0: emit a single ADDI rd,x0,imm[11:0].

Decomposition:
- Package rv_enc_pkg holds:
  - op enum: ADD 0, SUB 1, AND 2, OR 3, XOR 4, SLL 5, SRL 6, SRA 7, HAMD 8, ADDI 9, ANDI 10, ORI 11, XORI 12, SLLI 13, SRLI 14, SRAI 15, LW 16, JALR 17, SW 18, BEQ 19, BNE 20, LUI 21, JAL 22, LI 23.
  - Opcode constants, funct3/funct7 constants, and the state enum.
- One combinational sub-module, rv_enc_format: maps (op, rd, rs1, rs2, imm) -> 32-bit word. The top holds the FSM, handshake, LI sequencing and address counter.

Test Plan:
- ADD x3,x1,x2, out_ready=1 -> next cycle out_valid=1, out_inst=0x002081B3, out_addr=0; HAMD x5,x6,x7 -> 0x407372B3, out_addr=1.
- SRAI x4,x4,3 -> 0x40325213; BEQ x1,x2,imm=-8 -> 0xFE208CE3; back-to-back with in_valid held -> one word per cycle.
- LI x10,0x12345FFF -> 0x12346537 at addr A, then 0xFFF50513 at A+1; in_ready=0 during FIRST; LI x1,0x7FF -> single 0x7FF00093.
- Hold out_ready=0 for 5 cycles after ADD -> out_inst/out_addr stable, in_ready=0, address unchanged; release -> one fire, addr+1.
- in_op=27 accepted -> err high for 1 cycle, no out_valid, address unchanged; ADDR_W=2, emit 5 words -> addresses 0,1,2,3,0.
- Assert reset during LI between LUI and ADDI -> out_valid=0, out_addr=BASE_ADDR immediately; ADDI never emitted.
